// File: rtl/pgm_pkg.sv
// Shared types and defaults for the PGM packet-RAM replay sequencer.
package pgm_pkg;

    localparam int PGM_ADDR_W = 7;
    localparam int PGM_DATA_W = 134;
    localparam int PGM_RAM_W  = 144;
    localparam int PGM_GAP_W  = 16;
    localparam int PGM_CNT_W  = 32;

    // Word tag carried in data bits [133:132]
    localparam logic [1:0] TAG_HDR  = 2'b01;
    localparam logic [1:0] TAG_BODY = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SEND,
        ST_DRAIN,
        ST_GAP
    } pgm_state_e;

endpackage

// File: rtl/pgm_gap_timer.sv
// Loadable down-counter timing the idle gap between replayed copies.
module pgm_gap_timer #(
    parameter int GAP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [GAP_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires on the last gap cycle so the next read lands right after it
    assign expired = (cnt_q <= GAP_W'(1));

endmodule

// File: rtl/pgm_replay_ctrl.sv
// Replays the PGM packet RAM N times with an idle gap, arbitrating against bypass.
// Optional macro PGM_SEQ_INSERT_EN stamps sent_pkt_cnt into word 1 bits [31:0].
module pgm_replay_ctrl
    import pgm_pkg::*;
#(
    parameter int ADDR_W = PGM_ADDR_W,
    parameter int DATA_W = PGM_DATA_W,
    parameter int RAM_W  = PGM_RAM_W,
    parameter int GAP_W  = PGM_GAP_W,
    parameter int CNT_W  = PGM_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] cfg_last_addr,
    input  logic [CNT_W-1:0]  cfg_rep_cnt,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic              bypass_active,
    input  logic              in_alf,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [RAM_W-1:0]  ram_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_data_wr,
    output logic              out_valid,
    output logic              out_valid_wr,
    output logic              gen_active,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_pkt_cnt
);

    pgm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] last_q, last_d, addr_q, addr_d;
    logic [CNT_W-1:0]  rep_q, rep_d, cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              stop_seen_q, stop_seen_d, done_q, done_d;
    logic              vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
    logic              wr_p2_q, wr_p2_d, tail_p2_q, tail_p2_d;
    logic [DATA_W-1:0] data_p2_q, data_p2_d;
    logic              grant, pkt_end, replay_end, gap_load, gap_expired;
    logic              unused_ram_hi;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign grant      = !bypass_active && !in_alf;
    assign pkt_end    = (state_q == ST_DRAIN) && tail_p2_q;
    // A stop arriving together with the tail still ends the replay
    assign replay_end = stop_seen_q || stop ||
                        ((rep_q != '0) && (sat_inc(cnt_q) == rep_q));
    assign gap_load   = pkt_end && !replay_end && (gap_q != '0);

    pgm_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_q),
        .en       (state_q == ST_GAP),
        .expired  (gap_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_ARB;
            ST_ARB:   if (grant) state_d = (last_q == '0) ? ST_DRAIN : ST_SEND;
            ST_SEND:  if (addr_q == last_q) state_d = ST_DRAIN;
            ST_DRAIN: if (pkt_end) begin
                if (replay_end)       state_d = ST_IDLE;
                else if (gap_q == '0) state_d = ST_ARB;
                else                  state_d = ST_GAP;
            end
            ST_GAP:   if (gap_expired) state_d = ST_ARB;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_rd_en   = ((state_q == ST_ARB) && grant) || (state_q == ST_SEND);
        ram_rd_addr = (state_q == ST_SEND) ? addr_q : '0;
        gen_active  = ((state_q == ST_ARB) && grant) || (state_q == ST_SEND) ||
                      (state_q == ST_DRAIN);
        busy        = (state_q != ST_IDLE);
    end

    always_comb begin
        last_d      = last_q;
        rep_d       = rep_q;
        gap_d       = gap_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        stop_seen_d = stop_seen_q;
        if ((state_q == ST_IDLE) && start) begin
            last_d      = cfg_last_addr;
            rep_d       = cfg_rep_cnt;
            gap_d       = cfg_gap;
            cnt_d       = '0;
            stop_seen_d = 1'b0;
        end else if ((state_q != ST_IDLE) && stop) begin
            stop_seen_d = 1'b1;
        end
        if ((state_q == ST_ARB) && grant) begin
            addr_d = ADDR_W'(1);
        end else if (state_q == ST_SEND) begin
            addr_d = addr_q + 1'b1;
        end
        if (pkt_end) begin
            cnt_d = sat_inc(cnt_q);
        end
        done_d = pkt_end && replay_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= '0;
            rep_q       <= '0;
            gap_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            stop_seen_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            last_q      <= last_d;
            rep_q       <= rep_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            stop_seen_q <= stop_seen_d;
            done_q      <= done_d;
        end
    end

    // p1: read issued, RAM data arrives next cycle; p2: registered output word
`ifdef PGM_SEQ_INSERT_EN
    logic a1_p1_q, a1_p1_d;

    assign a1_p1_d = ram_rd_en && (ram_rd_addr == ADDR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            a1_p1_q <= 1'b0;
        end else begin
            a1_p1_q <= a1_p1_d;
        end
    end
`endif

    always_comb begin
        vld_p1_d  = ram_rd_en;
        last_p1_d = ram_rd_en && (ram_rd_addr == last_q);
        wr_p2_d   = vld_p1_q;
        tail_p2_d = vld_p1_q && last_p1_q;
        data_p2_d = data_p2_q;
        if (vld_p1_q) begin
            data_p2_d = ram_rd_data[DATA_W-1:0];
`ifdef PGM_SEQ_INSERT_EN
            if (a1_p1_q) begin
                data_p2_d[31:0] = 32'(cnt_q);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            wr_p2_q   <= 1'b0;
            tail_p2_q <= 1'b0;
            data_p2_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            last_p1_q <= last_p1_d;
            wr_p2_q   <= wr_p2_d;
            tail_p2_q <= tail_p2_d;
            data_p2_q <= data_p2_d;
        end
    end

    assign unused_ram_hi = ^ram_rd_data[RAM_W-1:DATA_W];

    assign out_data     = data_p2_q;
    assign out_data_wr  = wr_p2_q;
    assign out_valid    = wr_p2_q;
    assign out_valid_wr = tail_p2_q;
    assign done         = done_q;
    assign sent_pkt_cnt = cnt_q;

endmodule
